// File: rtl/f2_response_checker.sv
// -----------------------------------------------------------------------------
// f2_response_checker
// Sequential consumer for the f2 function-test interface. A 4-bit vector
// {a,b,c,d} is accepted with a valid/ready handshake. The checker then waits a
// settle window so the gate-level implementations can finish propagating.
// After that it samples the three implementation outputs once and compares
// each one with the golden function F = a&b&d | c&~d.
//
// Ports
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   vec_valid  in   1      stimulus vector present on vec
//   vec        in   4      {a,b,c,d}; vec[3]=a .. vec[0]=d
//   o_and_or   in   1      output of the AND-OR implementation
//   o_nand     in   1      output of the NAND implementation
//   o_nor      in   1      output of the NOR implementation
//   vec_ready  out  1      checker can accept a vector (high only in IDLE)
//   chk_done   out  1      one-cycle pulse: result fields valid
//   err_mask   out  3      {and_or,nand,nor} mismatch flags for the last vector
//   pass       out  1      sticky: no mismatch seen since reset
//   vec_count  out  CNT_W  vectors checked, wraps
//   err_count  out  CNT_W  vectors with any mismatch, saturates at all-ones
// -----------------------------------------------------------------------------
module f2_response_checker #(
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             vec_valid,
   input  logic [3:0]       vec,
   input  logic             o_and_or,
   input  logic             o_nand,
   input  logic             o_nor,
   output logic             vec_ready,
   output logic             chk_done,
   output logic [2:0]       err_mask,
   output logic             pass,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] err_count
);

   // A settle window of zero cycles makes no sense, so it is clamped to one.
   localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
   localparam int CW         = (SETTLE_EFF < 2) ? 1 : $clog2(SETTLE_EFF);

   localparam logic [CW-1:0]    CNT_LOAD  = CW'(SETTLE_EFF - 1);
   localparam logic [CW-1:0]    CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0]    CNT_STEP  = CW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_COMPARE = 2'd2
   } state_t;

   // Golden reference: F = a&b&d | c&~d with v = {a,b,c,d}.
   function automatic logic golden_f(input logic [3:0] v);
      return (v[3] & v[2] & v[0]) | (v[1] & ~v[0]);
   endfunction

   // Case inequality on purpose: an X or Z on an implementation output is
   // reported as a mismatch. In hardware it reduces to an ordinary compare.
   function automatic logic [2:0] mismatch_mask(input logic exp_v,
                                                input logic and_or_v,
                                                input logic nand_v,
                                                input logic nor_v);
      logic [2:0] m;
      m[2] = (and_or_v !== exp_v);
      m[1] = (nand_v   !== exp_v);
      m[0] = (nor_v    !== exp_v);
      return m;
   endfunction

   state_t             state_r, state_s;
   logic [CW-1:0]      cnt_r, cnt_s;
   logic [3:0]         vec_r, vec_s;
   logic               vec_ready_r, vec_ready_s;
   logic               chk_done_r, chk_done_s;
   logic [2:0]         err_mask_r, err_mask_s;
   logic               pass_r, pass_s;
   logic [CNT_W-1:0]   vec_count_r, vec_count_s;
   logic [CNT_W-1:0]   err_count_r, err_count_s;
   logic [2:0]         cmp_mask_s;

   // Next-state and next-output logic for the IDLE/SETTLE/COMPARE sequencer.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      vec_s       = vec_r;
      chk_done_s  = 1'b0;
      err_mask_s  = err_mask_r;
      pass_s      = pass_r;
      vec_count_s = vec_count_r;
      err_count_s = err_count_r;
      cmp_mask_s  = mismatch_mask(golden_f(vec_r), o_and_or, o_nand, o_nor);

      case (state_r)
         ST_IDLE: begin
            if (vec_valid && vec_ready_r) begin
               vec_s   = vec;
               cnt_s   = CNT_LOAD;
               state_s = ST_SETTLE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            // Inputs are ignored here; o_* glitches during settling are never seen.
            if (cnt_r == CNT_ZERO) begin
               state_s = ST_COMPARE;
            end else begin
               cnt_s = cnt_r - CNT_STEP;
            end
         end
         ST_COMPARE: begin
            err_mask_s  = cmp_mask_s;
            chk_done_s  = 1'b1;
            vec_count_s = vec_count_r + CNT_ONE;
            if (cmp_mask_s != 3'b000) begin
               pass_s = 1'b0;
               if (err_count_r != CNT_MAX) begin
                  err_count_s = err_count_r + CNT_ONE;
               end else begin
                  err_count_s = err_count_r;
               end
            end else begin
               pass_s = pass_r;
            end
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      // vec_ready is registered, so it is derived from the state being entered.
      vec_ready_s = (state_s == ST_IDLE);
   end

   // State and registered-output storage with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= CNT_ZERO;
         vec_r       <= 4'b0000;
         vec_ready_r <= 1'b1;
         chk_done_r  <= 1'b0;
         err_mask_r  <= 3'b000;
         pass_r      <= 1'b1;
         vec_count_r <= {CNT_W{1'b0}};
         err_count_r <= {CNT_W{1'b0}};
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         vec_r       <= vec_s;
         vec_ready_r <= vec_ready_s;
         chk_done_r  <= chk_done_s;
         err_mask_r  <= err_mask_s;
         pass_r      <= pass_s;
         vec_count_r <= vec_count_s;
         err_count_r <= err_count_s;
      end
   end

   assign vec_ready = vec_ready_r;
   assign chk_done  = chk_done_r;
   assign err_mask  = err_mask_r;
   assign pass      = pass_r;
   assign vec_count = vec_count_r;
   assign err_count = err_count_r;

endmodule

// File: tb/tb_f2_response_checker.sv
// Directed bench for f2_response_checker.
// dut1: SETTLE_CYCLES=4, CNT_W=8.
// dut2: SETTLE_CYCLES=0 (clamped to 1), CNT_W=2, used for the wrap and
//       saturation corners.
module tb_f2_response_checker;

   logic       clk = 1'b0;
   logic       rst1_n, rst2_n, vv1, vv2;
   logic [3:0] vec1, vec2;
   logic [2:0] o1, o2;

   logic       ready1, done1, pass1;
   logic [2:0] mask1;
   logic [7:0] vc1, ec1;
   logic       ready2, done2, pass2;
   logic [2:0] mask2;
   logic [1:0] vc2, ec2;

   int n_cmp  = 0;
   int n_fail = 0;
   int cur    = 1;
   int cyc    = 0;
   int prev_cyc;
   int n;
   int seen;
   logic xbit;

   logic [3:0] t4_v [6] = '{4'b0110, 4'b0101, 4'b1101, 4'b1001, 4'b0001, 4'b1010};
   logic       t4_f [6] = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b0,    1'b1};
   logic [1:0] t5_ec [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

   f2_response_checker #(.SETTLE_CYCLES(4), .CNT_W(8)) dut1 (
      .clk(clk), .rst_n(rst1_n), .vec_valid(vv1), .vec(vec1),
      .o_and_or(o1[2]), .o_nand(o1[1]), .o_nor(o1[0]),
      .vec_ready(ready1), .chk_done(done1), .err_mask(mask1), .pass(pass1),
      .vec_count(vc1), .err_count(ec1));

   f2_response_checker #(.SETTLE_CYCLES(0), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst2_n), .vec_valid(vv2), .vec(vec2),
      .o_and_or(o2[2]), .o_nand(o2[1]), .o_nor(o2[0]),
      .vec_ready(ready2), .chk_done(done2), .err_mask(mask2), .pass(pass2),
      .vec_count(vc2), .err_count(ec2));

   wire rdy_m  = (cur == 2) ? ready2 : ready1;
   wire done_m = (cur == 2) ? done2  : done1;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer one vector to the selected DUT and wait for its chk_done pulse.
   // Returns at the falling edge inside the chk_done cycle.
   task automatic send(input logic [3:0] v, input logic [2:0] o, input int lat_exp, input string tag);
      int k;
      @(negedge clk);
      if (cur == 2) begin vec2 = v; o2 = o; vv2 = 1'b1; end
      else          begin vec1 = v; o1 = o; vv1 = 1'b1; end
      k = 0;
      while (!rdy_m && k < 20) begin @(negedge clk); k++; end
      check({tag, "_ready"}, rdy_m, 1'b1);
      @(posedge clk); #1;
      vv1 = 1'b0; vv2 = 1'b0;
      k = 0;
      while (!done_m && k < 20) begin @(posedge clk); k++; @(negedge clk); end
      check({tag, "_lat"}, k, lat_exp);
   endtask

   initial begin
      rst1_n = 1'b0; rst2_n = 1'b0; vv1 = 1'b0; vv2 = 1'b0;
      vec1 = 4'b0000; vec2 = 4'b0000; o1 = 3'b000; o2 = 3'b000;

      // T1: reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("t1_ready", ready1, 1'b1);
      check("t1_done",  done1,  1'b0);
      check("t1_mask",  mask1,  3'b000);
      check("t1_pass",  pass1,  1'b1);
      check("t1_vc",    vc1,    8'd0);
      check("t1_ec",    ec1,    8'd0);
      @(posedge clk); #1;
      rst1_n = 1'b1; rst2_n = 1'b1;

      // T2: 0110 -> F=1, all implementations correct
      cur = 1;
      send(4'b0110, 3'b111, 5, "t2");
      check("t2_mask", mask1, 3'b000);
      check("t2_vc",   vc1,   8'd1);
      check("t2_ec",   ec1,   8'd0);
      check("t2_pass", pass1, 1'b1);
      @(negedge clk);
      check("t2_pulse", done1, 1'b0);

      // T3: 1101 -> F=1 with o_nor stuck at 0, then a good 0011 -> F=0
      send(4'b1101, 3'b110, 5, "t3a");
      check("t3a_mask", mask1, 3'b001);
      check("t3a_ec",   ec1,   8'd1);
      check("t3a_pass", pass1, 1'b0);
      @(negedge clk);
      check("t3_hold", mask1, 3'b001);
      send(4'b0011, 3'b000, 5, "t3b");
      check("t3b_mask", mask1, 3'b000);
      check("t3b_pass", pass1, 1'b0);
      check("t3b_vc",   vc1,   8'd3);

      // T4: six vectors with vec_valid held high. Each vector needs the IDLE
      // accept cycle, SETTLE_CYCLES settle cycles and one COMPARE cycle, so the
      // pulses are SETTLE_CYCLES+2 = 6 cycles apart.
      @(negedge clk);
      vec1 = t4_v[0]; o1 = {3{t4_f[0]}}; vv1 = 1'b1;
      prev_cyc = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n = 0;
         while (!done1 && n < 30) begin @(negedge clk); n++; end
         check("t4_done", done1, 1'b1);
         check("t4_mask", mask1, 3'b000);
         if (i > 0) check("t4_gap", cyc - prev_cyc, 6);
         prev_cyc = cyc;
         if (i < 5) begin vec1 = t4_v[i+1]; o1 = {3{t4_f[i+1]}}; end
         else       vv1 = 1'b0;
      end
      check("t4_vc", vc1, 8'd9);
      check("t4_ec", ec1, 8'd1);

      // T4 X: 0110 -> F=1 with o_nand unknown
      send(4'b0110, {1'b1, 1'bx, 1'b1}, 5, "t4x");
      xbit = (o1[1] !== 1'b1);
      check("t4x_mask", mask1, {1'b0, xbit, 1'b0});
      check("t4x_ec",   ec1,   8'd1 + {7'd0, xbit});
      check("t4x_vc",   vc1,   8'd10);

      // T6: reset asserted mid-SETTLE, between clock edges
      @(negedge clk);
      vec1 = 4'b1001; o1 = 3'b000; vv1 = 1'b1;
      @(posedge clk); #1;
      vv1 = 1'b0;
      @(posedge clk); #3;
      rst1_n = 1'b0;
      #1;
      check("t6_ready", ready1, 1'b1);
      check("t6_done",  done1,  1'b0);
      check("t6_mask",  mask1,  3'b000);
      check("t6_pass",  pass1,  1'b1);
      check("t6_vc",    vc1,    8'd0);
      check("t6_ec",    ec1,    8'd0);
      @(posedge clk); #1;
      rst1_n = 1'b1;
      seen = 0;
      repeat (10) begin @(negedge clk); if (done1) seen = 1; end
      check("t6_nodone", seen, 0);
      send(4'b0101, 3'b000, 5, "t6");
      check("t6_vc1",   vc1,   8'd1);
      check("t6_mask1", mask1, 3'b000);
      check("t6_pass1", pass1, 1'b1);

      // T5: CNT_W=2, settle window clamped to one cycle (latency 2).
      cur = 2;
      send(4'b1010, 3'b111, 2, "t5p0");
      send(4'b0000, 3'b000, 2, "t5p1");
      send(4'b1111, 3'b111, 2, "t5p2");
      send(4'b0100, 3'b000, 2, "t5p3");
      send(4'b1101, 3'b111, 2, "t5p4");
      check("t5_vc_wrap", vc2,   2'd1);
      check("t5_ec_pass", ec2,   2'd0);
      check("t5_pass",    pass2, 1'b1);
      @(negedge clk);
      rst2_n = 1'b0;
      @(posedge clk); #1;
      rst2_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(4'b0000, 3'b111, 2, "t5f");
         check("t5f_ec", ec2, t5_ec[i]);
      end
      check("t5_mask",   mask2, 3'b111);
      check("t5_ec_sat", ec2,   2'd3);
      check("t5_vc",     vc2,   2'd1);
      check("t5_fail",   pass2, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
